// File: rtl/fd_queue.sv
// Fetch-to-decode FIFO: DEPTH-entry queue with valid/ready handshake, flush and exception fence.
// Optional same-cycle bypass of an empty queue when FD_BYPASS_EN is defined.
module fd_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PKT_W   = 128,
   parameter int unsigned ALIAS_W = 6,
   parameter int unsigned IET_W   = 4,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic                         clk,
   input  logic                         clr,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PKT_W-1:0]             packet_in,
   input  logic [ALIAS_W-1:0]           BP_alias_in,
   input  logic                         IE_in,
   input  logic [IET_W-1:0]             IE_type_in,
   input  logic [ADDR_W-1:0]            BR_pred_target_in,
   input  logic                         BR_pred_T_NT_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PKT_W-1:0]             packet_out,
   output logic [ALIAS_W-1:0]           BP_alias_out,
   output logic                         IE_out,
   output logic [IET_W-1:0]             IE_type_out,
   output logic [ADDR_W-1:0]            BR_pred_target_out,
   output logic                         BR_pred_T_NT_out,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned BW     = PKT_W + ALIAS_W + 1 + IET_W + ADDR_W + 1;
   localparam int unsigned IE_POS = 1 + ADDR_W + IET_W;

   logic [BW-1:0]    r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr;
   logic [PTR_W-1:0] r_rd;
   logic [CNT_W-1:0] r_count;
   logic             r_fence;

   logic [BW-1:0]    w_in;
   logic [BW-1:0]    w_head;
   logic [BW-1:0]    w_out;
   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_byp;

   assign w_in    = {packet_in, BP_alias_in, IE_in, IE_type_in, BR_pred_target_in, BR_pred_T_NT_in};
   assign w_head  = r_mem[r_rd];
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

   // Ready depends only on registered state and flush, never on out_ready.
   assign in_ready = !w_full && !r_fence && !flush;

`ifdef FD_BYPASS_EN
   assign w_byp = w_empty && in_valid && in_ready && out_ready && !flush;
`else
   assign w_byp = 1'b0;
`endif

   assign w_push = in_valid && in_ready && !w_byp;
   assign w_pop  = !w_empty && out_ready && !flush;

   always_comb begin
      w_out = '0;
      if (w_byp)
         w_out = w_in;
      else if (!w_empty)
         w_out = w_head;
   end

   assign {packet_out, BP_alias_out, IE_out, IE_type_out, BR_pred_target_out, BR_pred_T_NT_out} = w_out;
   assign out_valid = !w_empty || w_byp;
   assign count     = r_count;
   assign full      = w_full;
   assign empty     = w_empty;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_fence <= 1'b0;
      end else if (flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_fence <= 1'b0;
      end else begin
         if (w_push)
            r_wr <= r_wr + PTR_W'(1);
         if (w_pop)
            r_rd <= r_rd + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         // A faulting push cannot coincide with a faulting pop: the fence blocks pushes meanwhile.
         if (w_pop && w_head[IE_POS])
            r_fence <= 1'b0;
         if (w_push && IE_in)
            r_fence <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr] <= w_in;
   end

endmodule

// File: tb/tb_fd_queue.sv
// Scoreboard bench for fd_queue: expected entries queued on accepted pushes, compared at the head each cycle.
module tb_fd_queue;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned PKT_W   = 128;
   localparam int unsigned ALIAS_W = 6;
   localparam int unsigned IET_W   = 4;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [PKT_W-1:0]   pkt;
      logic [ALIAS_W-1:0] alias_v;
      logic               ie;
      logic [IET_W-1:0]   iet;
      logic [ADDR_W-1:0]  tgt;
      logic               tnt;
   } bundle_t;

   logic               clk = 1'b0;
   logic               clr = 1'b1;
   logic               flush = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [PKT_W-1:0]   packet_in = '0;
   logic [ALIAS_W-1:0] BP_alias_in = '0;
   logic               IE_in = 1'b0;
   logic [IET_W-1:0]   IE_type_in = '0;
   logic [ADDR_W-1:0]  BR_pred_target_in = '0;
   logic               BR_pred_T_NT_in = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [PKT_W-1:0]   packet_out;
   logic [ALIAS_W-1:0] BP_alias_out;
   logic               IE_out;
   logic [IET_W-1:0]   IE_type_out;
   logic [ADDR_W-1:0]  BR_pred_target_out;
   logic               BR_pred_T_NT_out;
   logic [CNT_W-1:0]   count;
   logic               full;
   logic               empty;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   bundle_t     cur_in = '0;
   bundle_t     sb[$];
   bit          m_fence = 1'b0;

   fd_queue #(.DEPTH(DEPTH), .PKT_W(PKT_W), .ALIAS_W(ALIAS_W), .IET_W(IET_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .packet_in(packet_in), .BP_alias_in(BP_alias_in), .IE_in(IE_in), .IE_type_in(IE_type_in),
      .BR_pred_target_in(BR_pred_target_in), .BR_pred_T_NT_in(BR_pred_T_NT_in),
      .out_valid(out_valid), .out_ready(out_ready), .packet_out(packet_out),
      .BP_alias_out(BP_alias_out), .IE_out(IE_out), .IE_type_out(IE_type_out),
      .BR_pred_target_out(BR_pred_target_out), .BR_pred_T_NT_out(BR_pred_T_NT_out),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input logic [PKT_W-1:0] pkt, input bit ie, input logic [IET_W-1:0] iet,
                        input logic [ADDR_W-1:0] tgt);
      cur_in.pkt     = pkt;
      cur_in.alias_v = ALIAS_W'($urandom);
      cur_in.ie      = ie;
      cur_in.iet     = iet;
      cur_in.tgt     = tgt;
      cur_in.tnt     = 1'($urandom);
      in_valid          = v;
      packet_in         = cur_in.pkt;
      BP_alias_in       = cur_in.alias_v;
      IE_in             = cur_in.ie;
      IE_type_in        = cur_in.iet;
      BR_pred_target_in = cur_in.tgt;
      BR_pred_T_NT_in   = cur_in.tnt;
   endtask

   function automatic logic [PKT_W-1:0] apkt(input int unsigned n);
      return {4'hA, (PKT_W-4)'(n)};
   endfunction

   // One clock: compare outputs against the model mid-cycle, then advance the model at the edge.
   task automatic step();
      bit      m_empty, m_ready, m_byp, m_push, m_pop, m_flush;
      bundle_t exp_b;
      bundle_t in_b;
      @(negedge clk);
      m_empty = (sb.size() == 0);
      m_ready = (sb.size() != DEPTH) && !m_fence && !flush;
      m_byp   = 1'b0;
`ifdef FD_BYPASS_EN
      m_byp = m_empty && in_valid && m_ready && out_ready && !flush;
`endif
      exp_b = '0;
      if (m_byp)
         exp_b = cur_in;
      else if (!m_empty)
         exp_b = sb[0];
      check("count", PKT_W'(count), PKT_W'(sb.size()));
      check("empty", PKT_W'(empty), PKT_W'(m_empty));
      check("full", PKT_W'(full), PKT_W'(sb.size() == DEPTH));
      check("in_ready", PKT_W'(in_ready), PKT_W'(m_ready));
      check("out_valid", PKT_W'(out_valid), PKT_W'(m_byp || !m_empty));
      check("packet_out", packet_out, exp_b.pkt);
      check("alias_out", PKT_W'(BP_alias_out), PKT_W'(exp_b.alias_v));
      check("IE_out", PKT_W'(IE_out), PKT_W'(exp_b.ie));
      check("IE_type_out", PKT_W'(IE_type_out), PKT_W'(exp_b.iet));
      check("target_out", PKT_W'(BR_pred_target_out), PKT_W'(exp_b.tgt));
      check("tnt_out", PKT_W'(BR_pred_T_NT_out), PKT_W'(exp_b.tnt));
      m_push  = in_valid && m_ready && !m_byp;
      m_pop   = !m_empty && out_ready && !flush;
      m_flush = flush;
      in_b    = cur_in;
      @(posedge clk);
      #1;
      if (m_flush) begin
         sb.delete();
         m_fence = 1'b0;
      end else begin
         if (m_pop) begin
            if (sb[0].ie)
               m_fence = 1'b0;
            void'(sb.pop_front());
         end
         if (m_push) begin
            sb.push_back(in_b);
            if (in_b.ie)
               m_fence = 1'b1;
         end
      end
   endtask

   task automatic drain();
      drive(1'b0, '0, 1'b0, '0, '0);
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++)
         step();
   endtask

   initial begin
      // reset state while clr is held
      #12;
      check("rst_out_valid", PKT_W'(out_valid), '0);
      check("rst_count", PKT_W'(count), '0);
      check("rst_empty", PKT_W'(empty), PKT_W'(1));
      check("rst_full", PKT_W'(full), '0);
      check("rst_in_ready", PKT_W'(in_ready), PKT_W'(1));
      check("rst_packet", packet_out, '0);
      #1 clr = 1'b0;
      @(posedge clk);
      #1;

      // three pushes held, then drained in order
      out_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, apkt(i), 1'b0, '0, ADDR_W'($urandom));
         step();
      end
      drive(1'b0, '0, 1'b0, '0, '0);
      step();
      check("three_count", PKT_W'(count), PKT_W'(3));
      check("three_head", packet_out, apkt(1));
      drain();

      // fill to full, fifth offer refused, single pop frees one slot
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, apkt(16 + i), 1'b0, '0, ADDR_W'($urandom));
         step();
      end
      check("full_flag", PKT_W'(full), PKT_W'(1));
      check("full_in_ready", PKT_W'(in_ready), '0);
      drive(1'b0, '0, 1'b0, '0, '0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();
      check("after_pop_count", PKT_W'(count), PKT_W'(3));
      check("after_pop_ready", PKT_W'(in_ready), PKT_W'(1));
      drain();

      // steady streaming across pointer wrap
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, apkt(32 + i), 1'b0, '0, ADDR_W'($urandom));
         step();
      end
      drain();

      // exception fence behind two normal entries
      out_ready = 1'b0;
      drive(1'b1, apkt(64), 1'b0, '0, ADDR_W'($urandom));
      step();
      drive(1'b1, apkt(65), 1'b0, '0, ADDR_W'($urandom));
      step();
      drive(1'b1, apkt(66), 1'b1, 4'h3, ADDR_W'($urandom));
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, apkt(67 + i), 1'b0, '0, ADDR_W'($urandom));
         step();
      end
      check("fence_blocks", PKT_W'(in_ready), '0);
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, apkt(80 + i), 1'b0, '0, ADDR_W'($urandom));
         step();
      end
      drain();

      // flush with a concurrent offer
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, apkt(96 + i), 1'b0, '0, ADDR_W'($urandom));
         step();
      end
      flush = 1'b1;
      drive(1'b1, apkt(99), 1'b1, 4'h5, ADDR_W'($urandom));
      step();
      flush = 1'b0;
      drive(1'b0, '0, 1'b0, '0, '0);
      step();
      check("flush_empty", PKT_W'(empty), PKT_W'(1));
      check("flush_ready", PKT_W'(in_ready), PKT_W'(1));

      // asynchronous reset between edges
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, apkt(112 + i), 1'b0, '0, ADDR_W'($urandom));
         step();
      end
      drive(1'b0, '0, 1'b0, '0, '0);
      #2 clr = 1'b1;
      #1;
      check("async_out_valid", PKT_W'(out_valid), '0);
      check("async_count", PKT_W'(count), '0);
      #1 clr = 1'b0;
      sb.delete();
      m_fence = 1'b0;
      step();

      // empty queue offer with decode ready (bypass when enabled)
      out_ready = 1'b1;
      drive(1'b1, apkt(200), 1'b0, '0, 32'h0000_1000);
      step();
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/fd_queue.md
Name: fd_queue

Overview:
- Parametrised successor to the fetch-to-decode pipeline latch. Replaces the single-entry register stage with a DEPTH-entry FIFO between fetch and decode.
- Carries the same per-instruction bundle: valid, packet, BP alias, exception flag/type, predicted branch target, predicted T/NT.
- Adds valid/ready back-pressure, a one-cycle flush for branch-mispredict/exception redirect, occupancy status, and an exception fence that stops fetch behind a faulting packet.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PKT_W, 128, instruction packet width.
- ALIAS_W, 6, branch-predictor alias width.
- IET_W, 4, exception-type width.
- ADDR_W, 32, predicted-target width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  asynchronous active-high reset.
- flush  in  1  discard all entries this cycle.
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  queue accepts an entry.
- packet_in  in  PKT_W  instruction packet.
- BP_alias_in  in  ALIAS_W  predictor alias.
- IE_in  in  1  exception flag.
- IE_type_in  in  IET_W  exception type.
- BR_pred_target_in  in  ADDR_W  predicted target.
- BR_pred_T_NT_in  in  1  predicted taken.
- out_valid  out  1  head entry valid to decode.
- out_ready  in  1  decode consumes head.
- packet_out, BP_alias_out, IE_out, IE_type_out, BR_pred_target_out, BR_pred_T_NT_out  out  as inputs  head-entry fields.
- count  out  $clog2(DEPTH+1)  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (clr=1, async): rd/wr pointers 0, count 0, fence 0, storage don't-care. Outputs: out_valid 0, all payload outputs 0, empty 1, full 0, in_ready 1.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
- in_ready = !full & !fence & !flush. Purely from registered state plus flush, never from out_ready: no push into a full queue even when it pops that cycle.
- Push writes the entry at wr_ptr; wr_ptr increments mod DEPTH with natural wrap.
- Pop advances rd_ptr mod DEPTH.
- count += push - pop. Simultaneous push and pop leaves count unchanged.
- Latency: an entry pushed at edge N appears at the outputs after edge N, so it is visible one cycle later. Entries emerge strictly in FIFO order.
- out_valid = !empty. Payload outputs show the entry at rd_ptr. When empty, all payload outputs are forced to 0.
- Head entry is held stable while out_valid & !out_ready.
- Flush: at the next edge, count 0, pointers both reset to 0, fence cleared. Flush overrides push and pop in the same cycle. In the flush cycle out_valid is still driven from state, but decode must ignore it; pop is suppressed.
- Exception fence:
  - A push with IE_in=1 sets fence at that edge.
  - While fence=1, in_ready=0.
  - Fence clears at the edge where the faulting entry pops (pop with IE_out=1), or on flush.
  - Entries already queued ahead of the faulting entry drain normally.
- Reset asserted mid-operation discards all contents immediately, regardless of clk.

Optional Feature:
- FD_BYPASS_EN defined:
  - When empty & in_valid & in_ready & out_ready & !flush, the incoming bundle drives the outputs combinationally the same cycle, with out_valid=1, and is not written into storage.
  - If out_ready=0 the entry is written normally.
  - If the bypassed entry has IE_in=1, fence is not set.
  - Zero-cycle latency when empty.
- FD_BYPASS_EN undefined: minimum latency is one cycle; the output path comes only from storage.

Test Plan:
- Reset, then push packet 0xA…1, 0xA…2, 0xA…3 with out_ready=0 -> count=3, out_valid=1, packet_out=0xA…1. Then set out_ready=1 -> outputs 1, 2, 3 on consecutive cycles, then empty=1 with outputs 0.
- Fill DEPTH=4 with out_ready=0 -> full=1, in_ready=0, a 5th in_valid is dropped; pop once -> in_ready=1 the next cycle, count=3.
- Steady in_valid=out_ready=1 for 10 cycles across pointer wrap -> count stays 1, outputs in order, none lost.
- Push entry with IE_in=1, IE_type_in=4'h3 behind 2 normal entries -> in_ready=0 until the IE entry pops with IE_type_out=3; in_ready=1 the cycle after.
- With count=3, assert flush while also driving in_valid=1 -> next cycle count=0, empty=1, fence=0, and the flush-cycle input is not stored.
- Assert clr mid-stream between clock edges -> out_valid=0, count=0 immediately. With FD_BYPASS_EN: empty queue, in_valid=out_ready=1, BR_pred_target_in=0x0000_1000 -> same-cycle out_valid=1, BR_pred_target_out=0x0000_1000, count stays 0.
